// File: rtl/lut_neuron_prog.sv
// Programmable LUT neuron array: NUM_CH independent lookup tables fed by a
// 2-stage valid/ready pipeline, with a LOAD/RUN/DRAIN mode FSM that only
// permits table writes while the datapath is idle.
`timescale 1ns/1ps

module lut_neuron_prog #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int NUM_CH   = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DEPTH   = 1 << IN_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    input  logic                         cfg_commit,
    input  logic                         cfg_unlock,
    output logic                         cfg_err,
    output logic                         running,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*IN_BITS-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*OUT_BITS-1:0]   out_data
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic                         cfg_err_q, cfg_err_d;
    logic                         s1_valid_q;
    logic [NUM_CH*IN_BITS-1:0]    s1_data_q;
    logic                         out_valid_q;
    logic [NUM_CH*OUT_BITS-1:0]   out_data_q;
    logic [NUM_CH*OUT_BITS-1:0]   lookup;
    logic [OUT_BITS-1:0]          tbl_q [NUM_CH][DEPTH];

    logic ch_ok, wr_ok, en, accept, pipe_empty;

    // The channel select may be wider than needed when NUM_CH is not a power of two.
    assign ch_ok      = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
    assign wr_ok      = cfg_we && ch_ok && (state_q == LOAD);
    assign cfg_err_d  = cfg_we && !wr_ok;

    // Whole pipeline advances together whenever the output slot is free or being taken.
    assign en         = !out_valid_q || out_ready;
    assign in_ready   = (state_q == RUN) && en;
    assign accept     = in_valid && in_ready;
    assign pipe_empty = !s1_valid_q && !out_valid_q;

    assign running    = (state_q == RUN);
    assign cfg_err    = cfg_err_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // Mode state register and write-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            cfg_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Mode transitions: commit only from LOAD, unlock only from RUN, drain until empty.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (cfg_commit) state_d = RUN;
            RUN:     if (cfg_unlock) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Table storage: written only in LOAD with an in-range channel.
    // NOTE: the tables are a memory and deliberately have no reset, so contents
    // survive rst_n and the array can map onto RAM/LUT-RAM resources.
    always_ff @(posedge clk) begin
        if (wr_ok) tbl_q[cfg_ch][cfg_addr] <= cfg_data;
    end

    // Per-channel combinational lookup from the stage-1 register, all channels in parallel.
    always_comb begin
        lookup = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lookup[c*OUT_BITS +: OUT_BITS] = tbl_q[c][s1_data_q[c*IN_BITS +: IN_BITS]];
        end
    end

    // Two pipeline stages sharing one advance enable; both hold while output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            s1_valid_q  <= accept;
            if (accept) s1_data_q <= in_data;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) out_data_q <= lookup;
        end
    end

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Directed and scoreboard bench for lut_neuron_prog (NUM_CH=4, IN_BITS=6,
// OUT_BITS=2), plus a small NUM_CH=3 instance for out-of-range channel writes.
`timescale 1ns/1ps

module tb_lut_neuron_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we, cfg_commit, cfg_unlock;
    logic [1:0]  cfg_ch;
    logic [5:0]  cfg_addr;
    logic [1:0]  cfg_data;
    logic        cfg_err, running;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] in_data;
    logic [7:0]  out_data;

    // Second instance: NUM_CH=3 so cfg_ch=3 is representable and out of range.
    logic        b_cfg_we, b_cfg_commit, b_cfg_unlock;
    logic [1:0]  b_cfg_ch, b_cfg_addr;
    logic [0:0]  b_cfg_data;
    logic        b_cfg_err, b_running, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [5:0]  b_in_data;
    logic [2:0]  b_out_data;

    int total = 0;
    int bad   = 0;

    logic [1:0] mdl [4][64];

    typedef struct {
        logic [23:0] din;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    lut_neuron_prog #(.IN_BITS(6), .OUT_BITS(2), .NUM_CH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_unlock(cfg_unlock), .cfg_err(cfg_err),
        .running(running), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    lut_neuron_prog #(.IN_BITS(2), .OUT_BITS(1), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
        .cfg_commit(b_cfg_commit), .cfg_unlock(b_cfg_unlock), .cfg_err(b_cfg_err),
        .running(b_running), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [7:0] ref_lookup(input logic [23:0] d);
        logic [7:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[c*2 +: 2] = mdl[c][d[c*6 +: 6]];
        return r;
    endfunction

    // Writes every entry of mdl into the DUT; the final write carries the commit.
    task automatic load_from_mdl();
        for (int ch = 0; ch < 4; ch++) begin
            for (int a = 0; a < 64; a++) begin
                cfg_we     = 1'b1;
                cfg_ch     = 2'(ch);
                cfg_addr   = 6'(a);
                cfg_data   = mdl[ch][a];
                cfg_commit = (ch == 3) && (a == 63);
                tick();
            end
        end
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        check("load_running", running, 1);
        check("load_no_err", cfg_err, 0);
    endtask

    // One sample through an idle, unstalled pipeline.
    task automatic run_vec(input string name, input logic [23:0] din, input logic [7:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = din;
        tick();
        in_valid  = 1'b0;
        tick();
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_v, prev_data;
        logic       prev_stall;
        int         delivered;

        vecs[0] = '{din: {6'h31, 6'h31, 6'h31, 6'h31}, exp: 8'hE4};
        vecs[1] = '{din: {6'h20, 6'h03, 6'h02, 6'h01}, exp: 8'h89};
        vecs[2] = '{din: {6'h3F, 6'h00, 6'h07, 6'h39}, exp: 8'hFC};
        vecs[3] = '{din: {6'h10, 6'h3E, 6'h00, 6'h3F}, exp: 8'h51};
        vecs[4] = '{din: {6'h00, 6'h05, 6'h3D, 6'h00}, exp: 8'h25};

        rst_n = 1'b0;
        cfg_we = 0; cfg_ch = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0; cfg_unlock = 0;
        in_valid = 0; in_data = 0; out_ready = 1'b1;
        b_cfg_we = 0; b_cfg_ch = 0; b_cfg_addr = 0; b_cfg_data = 0; b_cfg_commit = 0;
        b_cfg_unlock = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1'b1;

        // Reset state
        #23;
        check("rst_running", running, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        tick();

        // LOAD never accepts samples
        in_valid = 1'b1;
        in_data  = vecs[0].din;
        settle();
        check("load_in_ready", in_ready, 0);
        tick();
        tick();
        check("load_no_output", out_valid, 0);
        in_valid = 1'b0;

        // Out-of-range channel on the NUM_CH=3 instance
        b_cfg_we = 1'b1;
        b_cfg_ch = 2'd3;
        tick();
        check("oor_err", b_cfg_err, 1);
        b_cfg_ch = 2'd2;
        tick();
        check("inrange_no_err", b_cfg_err, 0);
        b_cfg_we = 1'b0;

        // Fixed tables: ch0 all ones except 0x31/0x39, ch1=a[1:0], ch2=~a[1:0], ch3=a[5:4]
        for (int a = 0; a < 64; a++) begin
            logic [5:0] av;
            av = 6'(a);
            mdl[0][a] = (av == 6'h31 || av == 6'h39) ? 2'd0 : 2'd1;
            mdl[1][a] = av[1:0];
            mdl[2][a] = ~av[1:0];
            mdl[3][a] = av[5:4];
        end
        load_from_mdl();

        // Back-to-back stream: 2-cycle latency, 1 sample/cycle
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 5);
            if (i < 5) in_data = vecs[i].din;
            settle();
            if (i < 5) check("stream_in_ready", in_ready, 1);
            if (i >= 2) begin
                check("stream_valid", out_valid, 1);
                check("stream_data", out_data, vecs[i-2].exp);
            end else begin
                check("stream_latency", out_valid, 0);
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_end_idle", out_valid, 0);

        // Backpressure: 5 cycles of out_ready=0 with three samples offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vecs[0].din;
        settle();
        check("bp_acc_a", in_ready, 1);
        tick();
        in_data = vecs[1].din;
        settle();
        check("bp_acc_b", in_ready, 1);
        check("bp_b_valid", out_valid, 0);
        tick();
        in_data = vecs[2].din;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_stall_ready", in_ready, 0);
            check("bp_stall_valid", out_valid, 1);
            check("bp_stall_data", out_data, vecs[0].exp);
            tick();
        end
        out_ready = 1'b1;
        settle();
        check("bp_rel_ready", in_ready, 1);
        check("bp_out_a", out_data, vecs[0].exp);
        tick();
        in_valid = 1'b0;
        check("bp_out_b", out_data, vecs[1].exp);
        tick();
        check("bp_out_c_valid", out_valid, 1);
        check("bp_out_c", out_data, vecs[2].exp);
        tick();
        check("bp_done", out_valid, 0);

        // Write attempt in RUN is rejected and flagged for one cycle
        cfg_we   = 1'b1;
        cfg_ch   = 2'd1;
        cfg_addr = 6'd0;
        cfg_data = 2'b11;
        tick();
        cfg_we = 1'b0;
        check("run_we_err", cfg_err, 1);
        tick();
        check("run_we_err_pulse", cfg_err, 0);
        run_vec("run_we_table_kept", 24'h0, 8'h31);

        // Unlock with two samples in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vecs[0].din;
        tick();
        in_data   = vecs[1].din;
        tick();
        in_valid   = 1'b0;
        cfg_unlock = 1'b1;
        settle();
        check("unl_out_a", out_data, vecs[0].exp);
        tick();
        cfg_unlock = 1'b0;
        in_valid   = 1'b1;
        in_data    = vecs[2].din;
        settle();
        check("unl_running", running, 0);
        check("unl_in_ready", in_ready, 0);
        check("unl_out_b_valid", out_valid, 1);
        check("unl_out_b", out_data, vecs[1].exp);
        tick();
        in_valid = 1'b0;
        check("unl_empty", out_valid, 0);
        cfg_we   = 1'b1;
        cfg_ch   = 2'd0;
        cfg_addr = 6'd0;
        cfg_data = 2'd1;
        tick();
        check("drain_we_err", cfg_err, 1);
        tick();
        cfg_we = 1'b0;
        check("load_we_ok", cfg_err, 0);
        check("load_running_low", running, 0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("recommit_running", running, 1);

        // Reset with two samples in flight
        in_valid = 1'b1;
        in_data  = vecs[0].din;
        tick();
        in_data  = vecs[1].din;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_running", running, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid0", out_valid, 0);
        cfg_unlock = 1'b1;
        tick();
        cfg_unlock = 1'b0;
        check("post_rst_valid1", out_valid, 0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("post_rst_running", running, 1);
        check("post_rst_valid2", out_valid, 0);
        run_vec("post_rst_table", vecs[0].din, vecs[0].exp);
        run_vec("post_rst_table2", vecs[3].din, vecs[3].exp);

        // Random tables, random valid/ready, scoreboard
        cfg_unlock = 1'b1;
        tick();
        cfg_unlock = 1'b0;
        tick();
        tick();
        for (int ch = 0; ch < 4; ch++)
            for (int a = 0; a < 64; a++) mdl[ch][a] = 2'($urandom_range(0, 3));
        load_from_mdl();

        delivered  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 620; cyc++) begin
            logic drain_phase;
            drain_phase = (cyc >= 600);
            in_valid  = drain_phase ? 1'b0 : 1'($urandom_range(0, 1));
            in_data   = 24'($urandom);
            out_ready = drain_phase ? 1'b1 : ($urandom_range(0, 3) != 0);
            settle();
            if (prev_stall) check("sb_hold", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_spurious", 1, 0);
                end else begin
                    exp_v = q.pop_front();
                    check("sb_data", out_data, exp_v);
                    delivered++;
                end
            end
            if (in_valid && in_ready) q.push_back(ref_lookup(in_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
        end
        check("sb_leftover", q.size(), 0);
        check("sb_enough", delivered > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lut_neuron_prog.md
LUT_NEURON_PROG -- requirements
Module: lut_neuron_prog

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 6: address bits per neuron, i.e. fan-in times activation bits.
REQ-002 The block SHALL have parameter OUT_BITS, default 1: output bits per neuron.
REQ-003 The block SHALL have parameter NUM_CH, default 4: number of independent neurons (channels), each with its own table of 2^IN_BITS x OUT_BITS.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port cfg_we, input, width 1: table write strobe.
REQ-007 The block SHALL have port cfg_ch, input, width clog2(NUM_CH) (minimum 1): channel select for the table write.
REQ-008 The block SHALL have port cfg_addr, input, width IN_BITS: table entry index for the write.
REQ-009 The block SHALL have port cfg_data, input, width OUT_BITS: table entry value for the write.
REQ-010 The block SHALL have port cfg_commit, input, width 1: one-cycle pulse requesting LOAD->RUN.
REQ-011 The block SHALL have port cfg_unlock, input, width 1: one-cycle pulse requesting RUN->LOAD.
REQ-012 The block SHALL have port cfg_err, output, width 1: one-cycle pulse flagging a rejected table write.
REQ-013 The block SHALL have port running, output, width 1: high when the FSM is in RUN.
REQ-014 The block SHALL have port in_valid, input, width 1: input sample valid.
REQ-015 The block SHALL have port in_ready, output, width 1: input sample accepted when in_valid and in_ready are both high.
REQ-016 The block SHALL have port in_data, input, width NUM_CH*IN_BITS: channel c occupies bits [c*IN_BITS +: IN_BITS].
REQ-017 The block SHALL have port out_valid, output, width 1: output sample valid.
REQ-018 The block SHALL have port out_ready, input, width 1: downstream accept.
REQ-019 The block SHALL have port out_data, output, width NUM_CH*OUT_BITS: channel c occupies bits [c*OUT_BITS +: OUT_BITS].

Function
REQ-020 The FSM SHALL have exactly three states: LOAD, RUN, DRAIN.
REQ-021 In LOAD, cfg_we SHALL write cfg_data into table[cfg_ch][cfg_addr] at the clock edge, and in_ready SHALL be 0.
REQ-022 If cfg_ch >= NUM_CH, the write SHALL be dropped and cfg_err SHALL pulse on the next cycle.
REQ-023 LOAD->RUN SHALL occur on cfg_commit; a write and a commit in the same cycle SHALL both take effect, with the write landing before RUN.
REQ-024 In RUN and DRAIN, cfg_we SHALL leave the tables unchanged and cfg_err SHALL pulse on the next cycle.
REQ-025 RUN->DRAIN SHALL occur on cfg_unlock; cfg_unlock in any state other than RUN SHALL be ignored, as SHALL cfg_commit in any state other than LOAD.
REQ-026 DRAIN->LOAD SHALL occur on the first cycle both pipeline stages are empty; DRAIN SHALL take 0 extra cycles if the pipeline is already empty, i.e. LOAD is entered on the next edge.
REQ-027 The datapath SHALL be a 2-stage pipeline with a global advance enable en = !out_valid || out_ready.
REQ-028 Stage 1 SHALL register in_data and the valid bit on an accepted transfer when en is high.
REQ-029 Stage 2 SHALL register, per channel, table[c][s1_addr_c], plus the stage-1 valid bit, when en is high.
REQ-030 in_ready SHALL equal (state==RUN) && en.
REQ-031 Latency SHALL be exactly 2 cycles from the accepting edge to out_valid=1 when there is no backpressure, with throughput of 1 sample per cycle.
REQ-032 While out_valid=1 and out_ready=0, out_data and both stage registers SHALL hold unchanged and no input SHALL be accepted.
REQ-033 In DRAIN, samples already in flight SHALL complete and be delivered using the tables in force before the unlock; no new sample SHALL be accepted.
REQ-034 Every channel SHALL be looked up in the same cycle; there SHALL be no inter-channel dependency.
REQ-035 Table lookups SHALL be purely combinational from the stage-1 register, with no default or X output for any address in 0..2^IN_BITS-1.

Reset
REQ-036 On rst_n low the block SHALL asynchronously set: state=LOAD, running=0, in_ready=0, out_valid=0, out_data=0, both stage valid bits=0, cfg_err=0.
REQ-037 Reset SHALL NOT clear table contents; table contents after power-up are undefined until written.
REQ-038 Reset asserted mid-transfer SHALL discard all in-flight samples, with no out_valid after release until a new sample is accepted in RUN.
REQ-039 Deassertion of rst_n SHALL take effect at the first following clock edge.

Verification
REQ-040 Scenario: reset, load ch0 with all 64 entries of 1 except addresses 6'h31 and 6'h39 set to 0, commit, drive ch0 inputs 6'h31 then 6'h01 on consecutive cycles -> ch0 output bits 0 then 1 on cycles +2 and +3.
REQ-041 Scenario: hold out_ready=0 for 5 cycles with 3 samples offered -> out_data stable; exactly 2 samples in flight; in_ready=0; all 3 samples delivered in order after release.
REQ-042 Scenario: cfg_we in RUN to ch1 addr 0 -> cfg_err=1 for one cycle and the ch1 addr 0 output is unchanged; cfg_ch=NUM_CH in LOAD -> cfg_err=1.
REQ-043 Scenario: cfg_unlock with 2 samples in flight -> both delivered; LOAD reached after the pipeline is empty; running=0; in_ready=0.
REQ-044 Scenario: rst_n pulsed low between accept and output -> out_valid=0 immediately and the table values still read as loaded after a re-commit.
REQ-045 Scenario: random table contents and random valid/ready at NUM_CH=4, IN_BITS=6, OUT_BITS=2 -> scoreboard matches the reference lookup for every sample.
